imem_loader: RTL



---
 rtl/mips_pkg.sv | 27 ++
 rtl/imem_loader_asm.sv | 29 ++
 rtl/imem_loader.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS-side definitions: loader states, instruction-memory sizing.
// Imported by the loader, its byte assembler and the instruction memory.
package mips_pkg;

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    WORD,
    WRITE,
    CHK,
    DONE,
    ERROR
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int IMEM_DEPTH = 8192;
  localparam int INSTR_W    = 32;

  // Big-endian byte shift: newest byte lands in the low lane.
  function automatic logic [INSTR_W-1:0] shift_in(
    input logic [INSTR_W-1:0] word,
    input logic [7:0]         b
  );
    return {word[INSTR_W-9:0], b};
  endfunction

endpackage

// File: rtl/imem_loader_asm.sv
// Byte-to-word assembler: 32-bit shift register plus 2-bit byte index.
// word_valid pulses with the byte that completes a word.
import mips_pkg::*;

module imem_loader_asm (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_en,
  input  logic [7:0]         data,
  output logic [INSTR_W-1:0] word,
  output logic               word_valid
);

  logic [1:0] idx;

  // Shift each accepted byte in and count bytes within the word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word <= '0;
      idx  <= 2'd0;
    end else if (shift_en) begin
      word <= shift_in(word, data);
      idx  <= idx + 2'd1;
    end
  end

  assign word_valid = shift_en && (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: byte stream -> 32-bit words, CPU held until done.
// Optional trailer checksum: define IMEM_LOADER_CHECKSUM_EN.
import mips_pkg::*;

module imem_loader #(
  parameter int unsigned          DEPTH     = IMEM_DEPTH,
  parameter int                   ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  input  logic               start,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);

  // Low two bits forced clear so writes are always word-aligned.
  localparam logic [ADDR_W-1:0] BASE = BASE_ADDR & ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

  state_t      state, state_nx;
  logic        accept;
  logic [7:0]  count_hi;
  logic [15:0] count;
  logic [15:0] remaining;
  logic        word_valid;
  logic        last_word;
  logic        restart;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  chk;
`endif

  assign accept    = in_valid && in_ready;
  assign count     = {count_hi, in_data};
  assign last_word = (remaining == 16'd1);
  assign restart   = start && ((state == DONE) || (state == ERROR));

  imem_loader_asm u_asm (
    .clk        (clk),
    .reset      (reset),
    .shift_en   (accept && (state == WORD)),
    .data       (in_data),
    .word       (mem_wdata),
    .word_valid (word_valid)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CNT_HI;
    else       state <= state_nx;
  end

  // Next-state logic; every wait is open-ended with no timeout.
  always_comb begin
    state_nx = state;
    unique case (state)
      CNT_HI: if (accept) state_nx = CNT_LO;
      CNT_LO: begin
        if (accept) begin
          if (count == 16'd0)
            state_nx = DONE;
          else if (32'(count) > DEPTH)
            state_nx = ERROR;
          else
            state_nx = WORD;
        end
      end
      WORD:   if (word_valid) state_nx = WRITE;
      WRITE: begin
        if (!last_word)
          state_nx = WORD;
        else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nx = CHK;
`else
          state_nx = DONE;
`endif
        end
      end
      CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept)
          state_nx = (in_data == chk) ? DONE : ERROR;
`else
        state_nx = ERROR;
`endif
      end
      DONE:   if (start) state_nx = CNT_HI;
      ERROR:  if (start) state_nx = CNT_HI;
      default: state_nx = ERROR;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    in_ready = 1'b0;
    mem_we   = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state)
      CNT_HI: in_ready = 1'b1;
      CNT_LO: in_ready = 1'b1;
      WORD:   in_ready = 1'b1;
      WRITE:  mem_we   = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:    in_ready = 1'b1;
`else
      CHK:    in_ready = 1'b0;
`endif
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      ERROR:  error = 1'b1;
      default: error = 1'b1;
    endcase
  end

  // Word count capture, remaining counter and write address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_hi  <= 8'd0;
      remaining <= 16'd0;
      mem_addr  <= BASE;
    end else begin
      if (accept && (state == CNT_HI))
        count_hi <= in_data;
      if (accept && (state == CNT_LO))
        remaining <= count;
      if (state == WRITE) begin
        mem_addr  <= mem_addr + STEP;
        remaining <= remaining - 16'd1;
      end
      if (restart)
        mem_addr <= BASE;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // XOR of data bytes only; cleared when a new count is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      chk <= 8'd0;
    else if (accept && (state == CNT_LO))
      chk <= 8'd0;
    else if (accept && (state == WORD))
      chk <= chk ^ in_data;
  end
`endif

endmodule
